// File: rtl/ariane_pkg.sv
// Shared core types: shadow-stack FSM states and default stack depth.
// No logic here; latency and backpressure do not apply.
package ariane_pkg;

    localparam int unsigned SS_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        SS_DISABLED = 2'd0,
        SS_TRACKING = 2'd1,
        SS_CRASHED  = 2'd2
    } ss_state_e;

endpackage

// File: rtl/ss_lifo_ram.sv
// Shadow-stack storage, DEPTH x AW, one synchronous write port and one combinational read port.
// Write lands on the next clk edge, read is same-cycle; no backpressure.
module ss_lifo_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [AW-1:0]            wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [AW-1:0]            rd_dat
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/shadow_stack_guard.sv
// Return-address shadow stack: push on call, pop-and-compare on return; crash/mismatch registered (1 cycle).
// No backpressure. SHADOW_STACK_WRAP_EN makes overflow overwrite the oldest entry instead of crashing.
module shadow_stack_guard
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = SS_DEPTH_DEFAULT,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     call_valid_i,
    input  logic [AW-1:0]            call_addr_i,
    input  logic                     ret_valid_i,
    input  logic [AW-1:0]            ret_addr_i,
    input  logic                     flush_i,
    input  logic                     crash_ack_i,
    output logic                     crash_o,
    output logic                     mismatch_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic [7:0]               lost_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned DW = PW + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    ss_state_e     state, state_next;
    logic [PW-1:0] tos, tos_next, top_idx, wr_addr;
    logic [DW-1:0] depth, depth_next;
    logic [AW-1:0] top_dat;
    logic [7:0]    lost;
    logic          mismatch, mismatch_next;
    logic          active, has_top, full, clear;
    logic          do_ret, ret_chk, ret_bad, replace, do_call;
    logic          push, overflow, wr_en;

    assign top_idx = tos - 1'b1;
    assign has_top = (depth != '0);
    assign full    = (depth == FULL);
    assign clear   = flush_i && (state != SS_CRASHED);
    assign active  = (state == SS_TRACKING) && en_i && !flush_i;

    // An underflowing return is only forgiven while overflow-discarded entries remain.
    assign do_ret  = active && ret_valid_i;
    assign ret_chk = do_ret && has_top;
    assign ret_bad = do_ret && (has_top ? (top_dat != ret_addr_i) : (lost == 8'd0));
    assign replace = ret_chk && call_valid_i;
    assign do_call = active && call_valid_i && !replace;

`ifdef SHADOW_STACK_WRAP_EN
    logic [7:0] lost_next;
    logic       lost_dec;

    assign push     = do_call;
    assign overflow = 1'b0;
    assign lost_dec = do_ret && !has_top && (lost != 8'd0);

    always_comb begin
        lost_next = lost;
        if (clear) begin
            lost_next = 8'd0;
        end else if (push && full && (lost != 8'hFF)) begin
            lost_next = lost + 8'd1;
        end else if (lost_dec) begin
            lost_next = lost - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lost <= 8'd0;
        end else begin
            lost <= lost_next;
        end
    end
`else
    assign push     = do_call && !full;
    assign overflow = do_call && full;
    assign lost     = 8'd0;
`endif

    assign wr_en   = replace || push;
    assign wr_addr = replace ? top_idx : tos;

    always_comb begin
        tos_next   = tos;
        depth_next = depth;
        if (clear) begin
            depth_next = '0;
        end else if (ret_chk && !replace) begin
            tos_next   = top_idx;
            depth_next = depth - 1'b1;
        end else if (push) begin
            tos_next = tos + 1'b1;
            if (!full) begin
                depth_next = depth + 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        mismatch_next = 1'b0;
        case (state)
            SS_DISABLED: begin
                if (en_i) begin
                    state_next = SS_TRACKING;
                end
            end
            SS_TRACKING: begin
                if (!en_i) begin
                    state_next = SS_DISABLED;
                end else if (ret_bad) begin
                    state_next    = SS_CRASHED;
                    mismatch_next = 1'b1;
                end else if (overflow) begin
                    state_next = SS_CRASHED;
                end
            end
            SS_CRASHED: begin
                if (crash_ack_i) begin
                    state_next = en_i ? SS_TRACKING : SS_DISABLED;
                end
            end
            default: state_next = SS_DISABLED;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= SS_DISABLED;
            tos      <= '0;
            depth    <= '0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_next;
            tos      <= tos_next;
            depth    <= depth_next;
            mismatch <= mismatch_next;
        end
    end

    ss_lifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (call_addr_i),
        .rd_addr (top_idx),
        .rd_dat  (top_dat)
    );

    assign crash_o    = (state == SS_CRASHED);
    assign mismatch_o = mismatch;
    assign depth_o    = depth;
    assign lost_o     = lost;

endmodule

// File: tb/tb_shadow_stack_guard.sv
// Directed bench for shadow_stack_guard with a queue-based reference model checked every cycle.
module tb_shadow_stack_guard;

    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          call_v;
    logic [AW-1:0] call_a;
    logic          ret_v;
    logic [AW-1:0] ret_a;
    logic          flush;
    logic          ack;
    logic          crash;
    logic          mis;
    logic [4:0]    depth;
    logic [7:0]    lost;

    int n_chk  = 0;
    int n_fail = 0;

    shadow_stack_guard #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .call_valid_i (call_v),
        .call_addr_i  (call_a),
        .ret_valid_i  (ret_v),
        .ret_addr_i   (ret_a),
        .flush_i      (flush),
        .crash_ack_i  (ack),
        .crash_o      (crash),
        .mismatch_o   (mis),
        .depth_o      (depth),
        .lost_o       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 = disabled, 1 = tracking, 2 = crashed.
    logic [AW-1:0] m_stack[$];
    int            m_lost;
    int            m_state;
    bit            m_mis;

    always @(posedge clk or negedge rst_n) begin
        bit bad;
        bit replaced;
        if (!rst_n) begin
            m_stack.delete();
            m_lost  = 0;
            m_state = 0;
            m_mis   = 1'b0;
        end else begin
            m_mis = 1'b0;
            case (m_state)
                0: begin
                    if (flush) begin m_stack.delete(); m_lost = 0; end
                    if (en) m_state = 1;
                end
                1: begin
                    if (flush) begin
                        m_stack.delete();
                        m_lost = 0;
                        if (!en) m_state = 0;
                    end else if (!en) begin
                        m_state = 0;
                    end else begin
                        bad      = 1'b0;
                        replaced = 1'b0;
                        if (ret_v) begin
                            if (m_stack.size() > 0) begin
                                if (m_stack[m_stack.size()-1] != ret_a) bad = 1'b1;
                                if (call_v) begin
                                    m_stack[m_stack.size()-1] = call_a;
                                    replaced = 1'b1;
                                end else begin
                                    void'(m_stack.pop_back());
                                end
                            end else if (m_lost > 0) begin
                                m_lost--;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        if (call_v && !replaced) begin
                            if (m_stack.size() == DEPTH) begin
`ifdef SHADOW_STACK_WRAP_EN
                                void'(m_stack.pop_front());
                                m_stack.push_back(call_a);
                                if (m_lost < 255) m_lost++;
`else
                                m_state = 2;
`endif
                            end else begin
                                m_stack.push_back(call_a);
                            end
                        end
                        if (bad) begin
                            m_mis   = 1'b1;
                            m_state = 2;
                        end
                    end
                end
                default: begin
                    if (ack) m_state = en ? 1 : 0;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model crash_o",    crash, (m_state == 2) ? 64'd1 : 64'd0);
            chk("model mismatch_o", mis,   m_mis ? 64'd1 : 64'd0);
            chk("model depth_o",    depth, 64'(m_stack.size()));
            chk("model lost_o",     lost,  64'(m_lost));
        end
    end

    task automatic cyc(input logic c, input logic [AW-1:0] ca, input logic r,
                       input logic [AW-1:0] ra, input logic fl, input logic ak);
        call_v = c;
        call_a = ca;
        ret_v  = r;
        ret_a  = ra;
        flush  = fl;
        ack    = ak;
        @(posedge clk);
        #1;
        call_v = 1'b0;
        ret_v  = 1'b0;
        flush  = 1'b0;
        ack    = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic call(input logic [AW-1:0] a);
        cyc(1'b1, a, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic ret(input logic [AW-1:0] a);
        cyc(1'b0, '0, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic do_ack();
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        call_v = 1'b0;
        call_a = '0;
        ret_v  = 1'b0;
        ret_a  = '0;
        flush  = 1'b0;
        ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset crash_o",    crash, 0);
        chk("reset mismatch_o", mis,   0);
        chk("reset depth_o",    depth, 0);
        chk("reset lost_o",     lost,  0);
        rst_n = 1'b1;

        // Matched call/return
        en = 1'b1;
        idle();
        call(32'h8000_0104);
        chk("s1 depth after call", depth, 1);
        ret(32'h8000_0104);
        chk("s1 depth after ret", depth, 0);
        chk("s1 no mismatch", mis, 0);
        chk("s1 no crash", crash, 0);

        // Mismatched return, crash hold and acknowledge
        call(32'h8000_0104);
        ret(32'h8000_0200);
        chk("s2 mismatch pulse", mis, 1);
        chk("s2 crash raised", crash, 1);
        call(32'h0000_1234);
        chk("s2 mismatch one cycle", mis, 0);
        chk("s2 crash held", crash, 1);
        chk("s2 call ignored in crash", depth, 0);
        do_ack();
        chk("s2 crash cleared", crash, 0);
        call(32'h8000_0300);
        chk("s2 tracking after ack", depth, 1);
        ret(32'h8000_0300);
        chk("s2 matched after ack", crash, 0);

        // Seventeen calls into a 16-entry stack
        for (int i = 0; i < 16; i++) call(32'h8000_1000 + 32'(4 * i));
        chk("s3 depth full", depth, 16);
        chk("s3 no crash at full", crash, 0);
        call(32'h8000_1000 + 32'(4 * 16));
`ifdef SHADOW_STACK_WRAP_EN
        chk("s3 wrap depth", depth, 16);
        chk("s3 wrap lost", lost, 1);
        chk("s3 wrap no crash", crash, 0);
        for (int i = 16; i >= 0; i--) begin
            ret(32'h8000_1000 + 32'(4 * i));
            chk("s3 unwinding no mismatch", mis, 0);
        end
        chk("s3 lost drained", lost, 0);
        chk("s3 depth drained", depth, 0);
        chk("s3 no crash after unwind", crash, 0);
`else
        chk("s3 overflow crash", crash, 1);
        chk("s3 overflow no mismatch", mis, 0);
        chk("s3 overflow lost tied", lost, 0);
        chk("s3 overflow depth", depth, 16);
        do_ack();
        chk("s3 overflow acked", crash, 0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("s3 flush empties", depth, 0);
`endif

        // Flush wins over a same-cycle return
        call(32'h8000_2000);
        call(32'h8000_2004);
        call(32'h8000_2008);
        chk("s4 depth 3", depth, 3);
        cyc(1'b0, '0, 1'b1, 32'h8000_2008, 1'b1, 1'b0);
        chk("s4 flush depth", depth, 0);
        chk("s4 flush no mismatch", mis, 0);
        ret(32'h8000_2004);
        chk("s4 underflow mismatch", mis, 1);
        chk("s4 underflow crash", crash, 1);
        do_ack();
        chk("s4 acked", crash, 0);

        // Disabled return ignored, then async reset during crash
        en = 1'b0;
        ret(32'hDEAD_0000);
        chk("s5 disabled no mismatch", mis, 0);
        chk("s5 disabled no crash", crash, 0);
        en = 1'b1;
        idle();
        ret(32'hDEAD_0000);
        chk("s5 crash before reset", crash, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5 async crash drop", crash, 0);
        chk("s5 async mismatch drop", mis, 0);
        chk("s5 async depth", depth, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shadow_stack_guard.md
SHADOW_STACK_GUARD -- requirements
Module: shadow_stack_guard

Interface
REQ-001 SHALL take parameter DEPTH, default 16, as the number of shadow-stack entries, a power of two between 4 and 64.
REQ-002 SHALL take parameter AW, default 32, as the return-address width.
REQ-003 SHALL have port clk_i, input, 1 bit: clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en_i, input, 1 bit: enables checking; driven high only in user privilege.
REQ-006 SHALL have port call_valid_i, input, 1 bit: resolved call (JAL/JALR with rd=x1) from the branch unit.
REQ-007 SHALL have port call_addr_i, input, AW bits: de-obfuscated link address (next_pc) of the call.
REQ-008 SHALL have port ret_valid_i, input, 1 bit: resolved return (JALR rd=x0, rs1=x1).
REQ-009 SHALL have port ret_addr_i, input, AW bits: de-obfuscated return target, with bit 0 cleared.
REQ-010 SHALL have port flush_i, input, 1 bit: context switch; empties the stack.
REQ-011 SHALL have port crash_ack_i, input, 1 bit: acknowledges and clears a crash.
REQ-012 SHALL have port crash_o, output, 1 bit: sticky crash request towards the branch unit.
REQ-013 SHALL have port mismatch_o, output, 1 bit: one-cycle pulse on a detected return mismatch.
REQ-014 SHALL have port depth_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port lost_o, output, 8 bits: count of entries discarded by overflow, saturating at 255.

Function
REQ-016 SHALL implement FSM states DISABLED, TRACKING and CRASHED.
REQ-017 DISABLED SHALL ignore calls and returns and SHALL go to TRACKING on en_i=1.
REQ-018 TRACKING SHALL go to DISABLED on en_i=0, holding stack contents, and to CRASHED on a mismatch.
REQ-019 CRASHED SHALL ignore calls and returns and SHALL go to TRACKING (or to DISABLED if en_i=0) in the cycle after crash_ack_i=1.
REQ-020 A call in TRACKING SHALL push call_addr_i at the top-of-stack pointer, which wraps modulo DEPTH, and SHALL increment depth.
REQ-021 A return in TRACKING with depth>0 SHALL pop and compare the popped entry with ret_addr_i; on inequality it SHALL raise mismatch_o and crash_o one cycle later (registered).
REQ-022 A return with depth=0 and lost>0 SHALL be accepted unchecked and SHALL decrement lost.
REQ-023 A return with depth=0 and lost=0 SHALL be treated as a mismatch.
REQ-024 A simultaneous call and return SHALL check the return against the current top first, then replace the top with call_addr_i, leaving depth unchanged.
REQ-025 crash_o SHALL stay high from entry into CRASHED until the cycle after crash_ack_i.
REQ-026 mismatch_o SHALL pulse for exactly one cycle per mismatch.
REQ-027 flush_i SHALL set depth=0 and lost=0 in any state except CRASHED, and SHALL take priority over a same-cycle call or return.
REQ-028 lost_o SHALL saturate at 255 and SHALL not wrap.

Reset
REQ-029 On rst_ni=0 the FSM SHALL be in DISABLED with top pointer 0 and depth 0.
REQ-030 On rst_ni=0 lost_o, crash_o and mismatch_o SHALL be 0.
REQ-031 Stack storage SHALL not require reset.
REQ-032 Reset asserted mid-crash SHALL drop crash_o immediately (asynchronously).

Configuration
REQ-033 With SHADOW_STACK_WRAP_EN defined, a push at depth=DEPTH SHALL overwrite the oldest entry, keep depth at DEPTH and increment lost.
REQ-034 Without SHADOW_STACK_WRAP_EN, a push at depth=DEPTH SHALL enter CRASHED, raising crash_o one cycle later without a mismatch_o pulse; lost_o SHALL be tied to 0.

Structure
REQ-035 ss_state_e and the default value of DEPTH SHALL live in ariane_pkg.
REQ-036 Storage SHALL be a sub-module ss_lifo_ram: DEPTH x AW, one write port, one combinational read port.
REQ-037 The FSM, pointers and compare logic SHALL stay in shadow_stack_guard.

Verification
REQ-038 Bench SHALL cover: en=1; call 0x80000104; return 0x80000104 -> no mismatch, depth back to 0, crash_o=0.
REQ-039 Bench SHALL cover: call 0x80000104; return 0x80000200 -> mismatch_o pulse 1 cycle after return, crash_o held; crash_ack_i -> crash_o=0 next cycle, state TRACKING.
REQ-040 Bench SHALL cover: WRAP_EN, DEPTH=16; 17 calls, then 17 returns in reverse order -> 16 checked matches, 1 unchecked, lost_o 1->0, no crash.
REQ-041 Bench SHALL cover: no WRAP_EN; 17 calls -> crash_o=1 the cycle after the 17th call, mismatch_o=0.
REQ-042 Bench SHALL cover: 3 calls; flush_i together with a return -> depth 0, no check; next return -> mismatch, crash.
REQ-043 Bench SHALL cover: en=0 while a return 0xDEAD0000 arrives -> ignored; rst_ni low during CRASHED -> crash_o drops asynchronously.
